// File: rtl/axis_demux_pkg.sv
// Shared types and constants for the packet-granular 1-to-2 AXI-Stream demux.
// Route state encoding, default widths and port index constants live here.
package axis_demux_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int CNT_WIDTH_DEFAULT  = 16;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ROUTE_A = 2'b01,
      ROUTE_B = 2'b10
   } demux_state_e;

   // Held route for the remainder of a packet whose first beat chose `dest`
   function automatic demux_state_e route_state(input logic dest);
      return (dest == PORT_B) ? ROUTE_B : ROUTE_A;
   endfunction

endpackage

// File: rtl/axis_reg_stage.sv
// One-entry registered AXI-Stream slice: holds tdata/tlast behind a valid flag.
// load_ready is high when the slot is empty or being drained this cycle.
module axis_reg_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  axis_aclk,
   input  logic                  axis_areset,
   input  logic [DATA_WIDTH-1:0] in_tdata,
   input  logic                  in_tlast,
   input  logic                  in_tvalid,
   output logic                  load_ready,
   output logic                  load,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  last_q;

   assign load_ready = ~valid_q | m_axis_tready;
   assign load       = in_tvalid & load_ready;

   // A simultaneous load and drain keeps valid set and replaces the payload
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= in_tdata;
         last_q  <= in_tlast;
      end else if (m_axis_tready && valid_q) begin
         valid_q <= 1'b0;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q;

endmodule

// File: rtl/axis_demux.sv
// Packet-granular 1-to-2 AXI-Stream router: tdest on the first beat picks port A
// or B and the route is held until tlast. Each port sits behind a register stage.
module axis_demux
   import axis_demux_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
   input  logic                  axis_aclk,
   input  logic                  axis_areset,

   input  logic [DATA_WIDTH-1:0] s0k_axis_tdata,
   input  logic                  s0k_axis_tvalid,
   output logic                  s0k_axis_tready,
   input  logic                  s0k_axis_tlast,
   input  logic                  s0k_axis_tdest,

   output logic [DATA_WIDTH-1:0] m0a_axis_tdata,
   output logic                  m0a_axis_tvalid,
   input  logic                  m0a_axis_tready,
   output logic                  m0a_axis_tlast,

   output logic [DATA_WIDTH-1:0] m0b_axis_tdata,
   output logic                  m0b_axis_tvalid,
   input  logic                  m0b_axis_tready,
   output logic                  m0b_axis_tlast,

   output logic [CNT_WIDTH-1:0]  pkt_cnt_a,
   output logic [CNT_WIDTH-1:0]  pkt_cnt_b
);

   demux_state_e state;
   logic         dst;
   logic         accept;
   logic         ready_a;
   logic         ready_b;
   logic         load_a;
   logic         load_b;

   // Only a first beat (IDLE, or an unrecognised code) consults tdest
   always_comb begin
      dst = s0k_axis_tdest;
      case (state)
         ROUTE_A: dst = PORT_A;
         ROUTE_B: dst = PORT_B;
         default: dst = s0k_axis_tdest;
      endcase
   end

   assign s0k_axis_tready = (dst == PORT_B) ? ready_b : ready_a;
   assign accept          = s0k_axis_tvalid & s0k_axis_tready;

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept && !s0k_axis_tlast)
                  state <= route_state(s0k_axis_tdest);
            end
            ROUTE_A, ROUTE_B: begin
               if (accept && s0k_axis_tlast)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   axis_reg_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage_a (
      .axis_aclk     (axis_aclk),
      .axis_areset   (axis_areset),
      .in_tdata      (s0k_axis_tdata),
      .in_tlast      (s0k_axis_tlast),
      .in_tvalid     (s0k_axis_tvalid && (dst == PORT_A)),
      .load_ready    (ready_a),
      .load          (load_a),
      .m_axis_tdata  (m0a_axis_tdata),
      .m_axis_tvalid (m0a_axis_tvalid),
      .m_axis_tlast  (m0a_axis_tlast),
      .m_axis_tready (m0a_axis_tready)
   );

   axis_reg_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage_b (
      .axis_aclk     (axis_aclk),
      .axis_areset   (axis_areset),
      .in_tdata      (s0k_axis_tdata),
      .in_tlast      (s0k_axis_tlast),
      .in_tvalid     (s0k_axis_tvalid && (dst == PORT_B)),
      .load_ready    (ready_b),
      .load          (load_b),
      .m_axis_tdata  (m0b_axis_tdata),
      .m_axis_tvalid (m0b_axis_tvalid),
      .m_axis_tlast  (m0b_axis_tlast),
      .m_axis_tready (m0b_axis_tready)
   );

   // A packet counts as forwarded once its tlast beat is captured by the stage
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         pkt_cnt_a <= '0;
         pkt_cnt_b <= '0;
      end else begin
         if (load_a && s0k_axis_tlast)
            pkt_cnt_a <= pkt_cnt_a + CNT_WIDTH'(1);
         if (load_b && s0k_axis_tlast)
            pkt_cnt_b <= pkt_cnt_b + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_axis_demux.sv
// Scoreboard bench for axis_demux: expected beats are queued per port as they
// are driven and popped as each output port completes a handshake.
module tb_axis_demux;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          axis_aclk = 1'b0;
   logic          axis_areset;
   logic [DW-1:0] s0k_axis_tdata;
   logic          s0k_axis_tvalid;
   logic          s0k_axis_tready;
   logic          s0k_axis_tlast;
   logic          s0k_axis_tdest;
   logic [DW-1:0] m0a_axis_tdata;
   logic          m0a_axis_tvalid;
   logic          m0a_axis_tready;
   logic          m0a_axis_tlast;
   logic [DW-1:0] m0b_axis_tdata;
   logic          m0b_axis_tvalid;
   logic          m0b_axis_tready;
   logic          m0b_axis_tlast;
   logic [CW-1:0] pkt_cnt_a;
   logic [CW-1:0] pkt_cnt_b;

   int vectors = 0;
   int miscompares = 0;

   logic [DW:0]   q_a[$];
   logic [DW:0]   q_b[$];
   logic [CW-1:0] cnt_a_exp = '0;
   logic [CW-1:0] cnt_b_exp = '0;

   always #5 axis_aclk = ~axis_aclk;

   axis_demux #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .axis_aclk       (axis_aclk),
      .axis_areset     (axis_areset),
      .s0k_axis_tdata  (s0k_axis_tdata),
      .s0k_axis_tvalid (s0k_axis_tvalid),
      .s0k_axis_tready (s0k_axis_tready),
      .s0k_axis_tlast  (s0k_axis_tlast),
      .s0k_axis_tdest  (s0k_axis_tdest),
      .m0a_axis_tdata  (m0a_axis_tdata),
      .m0a_axis_tvalid (m0a_axis_tvalid),
      .m0a_axis_tready (m0a_axis_tready),
      .m0a_axis_tlast  (m0a_axis_tlast),
      .m0b_axis_tdata  (m0b_axis_tdata),
      .m0b_axis_tvalid (m0b_axis_tvalid),
      .m0b_axis_tready (m0b_axis_tready),
      .m0b_axis_tlast  (m0b_axis_tlast),
      .pkt_cnt_a       (pkt_cnt_a),
      .pkt_cnt_b       (pkt_cnt_b)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives one beat starting just after a falling edge; returns at the falling
   // edge following its acceptance, reporting how many cycles it stalled.
   task automatic applyStimulus(input logic [DW-1:0] data, input logic last,
                                input logic dest, output int stalls);
      bit done = 0;
      int n = 0;
      s0k_axis_tdata  = data;
      s0k_axis_tlast  = last;
      s0k_axis_tdest  = dest;
      s0k_axis_tvalid = 1'b1;
      stalls = 0;
      while (!done && n < 200) begin
         #3;
         if (s0k_axis_tready) done = 1;
         @(negedge axis_aclk);
         if (!done) stalls++;
         n++;
      end
      if (!done) checkOutput("accept_timeout", 0, 1);
      s0k_axis_tvalid = 1'b0;
   endtask

   task automatic sendPacket(input logic first_dest, input logic later_dest, input int beats,
                             input logic [DW-1:0] base, output int total_stalls);
      int st;
      total_stalls = 0;
      for (int i = 0; i < beats; i++) begin
         logic last;
         last = (i == beats - 1);
         if (first_dest) q_b.push_back({last, base + DW'(i)});
         else            q_a.push_back({last, base + DW'(i)});
         applyStimulus(base + DW'(i), last, (i == 0) ? first_dest : later_dest, st);
         total_stalls += st;
         if (last) begin
            if (first_dest) cnt_b_exp++;
            else            cnt_a_exp++;
         end
      end
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
         @(negedge axis_aclk);
         n++;
      end
      checkOutput("drain_left", 64'(q_a.size() + q_b.size()), 0);
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_cnt_a"}, 64'(pkt_cnt_a), 64'(cnt_a_exp));
      checkOutput({tag, "_cnt_b"}, 64'(pkt_cnt_b), 64'(cnt_b_exp));
   endtask

   // Output monitor: samples 3 time units after each falling edge
   logic        stall_a = 0, stall_b = 0;
   logic [DW:0] held_a, held_b;
   always begin
      logic [DW:0] e;
      @(negedge axis_aclk);
      #3;
      if (axis_areset) begin
         stall_a = 0;
         stall_b = 0;
      end else begin
         if (m0a_axis_tvalid) begin
            if (stall_a) checkOutput("a_stable", 64'({m0a_axis_tlast, m0a_axis_tdata}), 64'(held_a));
            if (m0a_axis_tready) begin
               if (q_a.size() == 0) checkOutput("a_unexpected", 64'({m0a_axis_tlast, m0a_axis_tdata}), 64'hDEAD);
               else begin
                  e = q_a.pop_front();
                  checkOutput("a_beat", 64'({m0a_axis_tlast, m0a_axis_tdata}), 64'(e));
               end
               stall_a = 0;
            end else begin
               stall_a = 1;
               held_a  = {m0a_axis_tlast, m0a_axis_tdata};
            end
         end else stall_a = 0;
         if (m0b_axis_tvalid) begin
            if (stall_b) checkOutput("b_stable", 64'({m0b_axis_tlast, m0b_axis_tdata}), 64'(held_b));
            if (m0b_axis_tready) begin
               if (q_b.size() == 0) checkOutput("b_unexpected", 64'({m0b_axis_tlast, m0b_axis_tdata}), 64'hDEAD);
               else begin
                  e = q_b.pop_front();
                  checkOutput("b_beat", 64'({m0b_axis_tlast, m0b_axis_tdata}), 64'(e));
               end
               stall_b = 0;
            end else begin
               stall_b = 1;
               held_b  = {m0b_axis_tlast, m0b_axis_tdata};
            end
         end else stall_b = 0;
      end
   end

   initial begin
      int st;
      axis_areset     = 1'b1;
      s0k_axis_tdata  = '0;
      s0k_axis_tvalid = 1'b0;
      s0k_axis_tlast  = 1'b0;
      s0k_axis_tdest  = 1'b0;
      m0a_axis_tready = 1'b1;
      m0b_axis_tready = 1'b1;

      repeat (3) @(negedge axis_aclk);
      #1;
      checkOutput("rst_a_valid", 64'(m0a_axis_tvalid), 0);
      checkOutput("rst_b_valid", 64'(m0b_axis_tvalid), 0);
      checkOutput("rst_a_data", 64'({m0a_axis_tlast, m0a_axis_tdata}), 0);
      checkOutput("rst_b_data", 64'({m0b_axis_tlast, m0b_axis_tdata}), 0);
      checkOutput("rst_s_ready", 64'(s0k_axis_tready), 1);
      checkCounters("rst");
      @(negedge axis_aclk);
      axis_areset = 1'b0;
      @(negedge axis_aclk);

      $display("[TB] 4-beat packet to A");
      sendPacket(1'b0, 1'b0, 4, 32'h10, st);
      checkOutput("a_pkt_stalls", 64'(st), 0);
      waitDrain();
      checkCounters("pkt_a");

      $display("[TB] 3-beat packet to B with later tdest=0");
      sendPacket(1'b1, 1'b0, 3, 32'h20, st);
      checkOutput("b_pkt_stalls", 64'(st), 0);
      waitDrain();
      checkCounters("pkt_b");

      $display("[TB] alternating single-beat packets");
      begin
         int tot = 0;
         for (int i = 0; i < 4; i++) begin
            sendPacket(logic'(i % 2), 1'b0, 1, 32'h30 + DW'(i), st);
            tot += st;
         end
         checkOutput("alt_stalls", 64'(tot), 0);
      end
      waitDrain();
      checkCounters("alt");

      $display("[TB] head-of-line blocking behind stalled A");
      m0a_axis_tready = 1'b0;
      fork
         begin
            sendPacket(1'b0, 1'b0, 2, 32'h40, st);
            sendPacket(1'b1, 1'b0, 1, 32'h50, st);
         end
         begin
            repeat (5) begin
               @(negedge axis_aclk);
               #4;
               checkOutput("hol_s_ready", 64'(s0k_axis_tready), 0);
               checkOutput("hol_b_valid", 64'(m0b_axis_tvalid), 0);
            end
            @(negedge axis_aclk);
            m0a_axis_tready = 1'b1;
         end
      join
      waitDrain();
      checkCounters("hol");

      $display("[TB] reset mid-packet");
      q_a.push_back({1'b0, 32'h70});
      applyStimulus(32'h70, 1'b0, 1'b0, st);
      q_a.push_back({1'b0, 32'h71});
      applyStimulus(32'h71, 1'b0, 1'b1, st);
      #2;
      axis_areset = 1'b1;
      q_a.delete();
      q_b.delete();
      cnt_a_exp = '0;
      cnt_b_exp = '0;
      #1;
      checkOutput("mid_rst_a_valid", 64'(m0a_axis_tvalid), 0);
      checkCounters("mid_rst");
      @(negedge axis_aclk);
      axis_areset = 1'b0;
      @(negedge axis_aclk);
      sendPacket(1'b1, 1'b0, 1, 32'h60, st);
      waitDrain();
      checkCounters("post_rst");
      checkOutput("post_rst_cnt_b_one", 64'(pkt_cnt_b), 1);

      $display("[TB] counter wrap on port A");
      for (int i = 0; i < 65535; i++) sendPacket(1'b0, 1'b0, 1, DW'(i), st);
      checkOutput("wrap_cnt_a_max", 64'(pkt_cnt_a), 64'hFFFF);
      sendPacket(1'b0, 1'b0, 1, 32'hFFFF, st);
      checkOutput("wrap_cnt_a_zero", 64'(pkt_cnt_a), 0);
      waitDrain();
      checkCounters("wrap");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
